// File: rtl/axis_frame_fifo_ex.sv
// axis_frame_fifo_ex: AXI-Stream frame FIFO with commit/rollback.
// A frame becomes visible to the read side only when its tlast is accepted
// with tuser=0. Bad frames (tuser=1), frames larger than the storage, and
// (with DROP_WHEN_FULL=1) frames that do not fit are rolled back and never
// reach the output.
// Optional status pulses (good_frame/bad_frame/overflow) are built only when
// the macro AXIS_FRAME_FIFO_EX_STATUS_EN is defined; otherwise they are tied 0.
module axis_frame_fifo_ex #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_WIDTH     = (DATA_WIDTH+7)/8,
  parameter int DROP_WHEN_FULL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic [ADDR_WIDTH:0]   frame_count,
  output logic                  overflow,
  output logic                  bad_frame,
  output logic                  good_frame
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  typedef struct packed {
    logic                  tlast;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [DATA_WIDTH-1:0] tdata;
  } beat_t;

  beat_t mem [DEPTH];

  ptr_t  wr_ptr, wr_ptr_next;          // committed frames end here
  ptr_t  wr_ptr_cur, wr_ptr_cur_next;  // in-progress frame end
  ptr_t  rd_ptr;
  logic  dropping, dropping_next;
  beat_t beat_in;
  beat_t out_beat;
  logic  out_valid;

  logic  empty, full_cur, oversize, tready_bp;
  logic  accept, wr_en, commit, rd_en, load_out, sent_last;

  assign beat_in  = {input_axis_tlast, input_axis_tkeep, input_axis_tdata};

  assign empty    = (wr_ptr == rd_ptr);
  assign full_cur = ((wr_ptr_cur - rd_ptr) == ptr_t'(DEPTH));
  // The in-progress frame alone occupies all of storage: it can never commit,
  // so it must be swallowed rather than back-pressured (otherwise deadlock).
  assign oversize = full_cur & (wr_ptr == rd_ptr);

  // Back-pressure only while a fitting frame waits for the reader to drain.
  assign tready_bp         = rst_n & (~full_cur | dropping | oversize);
  assign input_axis_tready = (DROP_WHEN_FULL != 0) ? 1'b1 : tready_bp;

  assign accept = input_axis_tvalid & input_axis_tready;

  // Write side: store, commit, roll back or enter/leave drop mode.
  always_comb begin
    wr_en           = 1'b0;
    commit          = 1'b0;
    wr_ptr_next     = wr_ptr;
    wr_ptr_cur_next = wr_ptr_cur;
    dropping_next   = dropping;
    if (accept) begin
      if (dropping || full_cur) begin
        // With back-pressure on, full_cur is only accepted when oversize.
        dropping_next = 1'b1;
        if (input_axis_tlast) begin
          wr_ptr_cur_next = wr_ptr;
          dropping_next   = 1'b0;
        end
      end else begin
        wr_en           = 1'b1;
        wr_ptr_cur_next = wr_ptr_cur + 1'b1;
        if (input_axis_tlast) begin
          if (input_axis_tuser) begin
            wr_ptr_cur_next = wr_ptr;
          end else begin
            wr_ptr_next = wr_ptr_cur + 1'b1;
            commit      = 1'b1;
          end
        end
      end
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= beat_in;
  end

  // Write-side pointer and drop-state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      wr_ptr_cur <= '0;
      dropping   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      wr_ptr_cur <= wr_ptr_cur_next;
      dropping   <= dropping_next;
    end
  end

  // Output register refills whenever it is empty or being consumed.
  assign load_out  = output_axis_tready | ~out_valid;
  assign rd_en     = load_out & ~empty;
  assign sent_last = out_valid & output_axis_tready & out_beat.tlast;

  // Read pointer and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      out_beat  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load_out) out_valid <= ~empty;
      if (rd_en) begin
        out_beat <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  // Committed-but-not-fully-sent frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else begin
      case ({commit, sent_last})
        2'b10:   frame_count <= frame_count + 1'b1;
        2'b01:   frame_count <= frame_count - 1'b1;
        default: frame_count <= frame_count;
      endcase
    end
  end

  assign output_axis_tdata  = out_beat.tdata;
  assign output_axis_tkeep  = out_beat.tkeep;
  assign output_axis_tlast  = out_beat.tlast;
  assign output_axis_tvalid = out_valid;

`ifdef AXIS_FRAME_FIFO_EX_STATUS_EN
  logic bad_evt, ovf_evt;
  assign bad_evt = accept & ~dropping & ~full_cur & input_axis_tlast & input_axis_tuser;
  assign ovf_evt = accept & (dropping | full_cur) & input_axis_tlast;

  // One-cycle status pulses, registered from the write-side events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      good_frame <= 1'b0;
      bad_frame  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      good_frame <= commit;
      bad_frame  <= bad_evt;
      overflow   <= ovf_evt;
    end
  end
`else
  assign good_frame = 1'b0;
  assign bad_frame  = 1'b0;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_fifo_ex.sv
// tb_axis_frame_fifo_ex: scoreboard bench for axis_frame_fifo_ex.
// Two instances (DROP_WHEN_FULL=0 and =1) share the stimulus; `sel` picks
// the one being observed. Each test starts from reset.
module tb_axis_frame_fifo_ex;

`ifdef AXIS_FRAME_FIFO_EX_STATUS_EN
  localparam int STATUS = 1;
`else
  localparam int STATUS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] in_tdata = '0;
  logic       in_tkeep = 1'b1;
  logic       in_tvalid = 1'b0, in_tlast = 1'b0, in_tuser = 1'b0;
  logic       otready_set = 1'b1, rnd_bit = 1'b0, rand_en = 1'b0;
  logic       o_tready;
  logic       sel = 1'b0;

  logic [7:0] d0_tdata, d1_tdata;
  logic       d0_tkeep, d1_tkeep, d0_tvalid, d1_tvalid, d0_tlast, d1_tlast;
  logic       d0_tready, d1_tready;
  logic [2:0] d0_fc, d1_fc;
  logic       d0_ov, d1_ov, d0_bad, d1_bad, d0_good, d1_good;

  logic [7:0] m_tdata;
  logic       m_tkeep, m_tvalid, m_tlast, m_in_tready, m_ov, m_bad, m_good;
  logic [2:0] m_fc;

  assign o_tready = rand_en ? rnd_bit : otready_set;

  axis_frame_fifo_ex #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .DROP_WHEN_FULL(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .input_axis_tdata(in_tdata), .input_axis_tkeep(in_tkeep),
    .input_axis_tvalid(in_tvalid), .input_axis_tready(d0_tready),
    .input_axis_tlast(in_tlast), .input_axis_tuser(in_tuser),
    .output_axis_tdata(d0_tdata), .output_axis_tkeep(d0_tkeep),
    .output_axis_tvalid(d0_tvalid), .output_axis_tready(o_tready),
    .output_axis_tlast(d0_tlast), .frame_count(d0_fc),
    .overflow(d0_ov), .bad_frame(d0_bad), .good_frame(d0_good)
  );

  axis_frame_fifo_ex #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .DROP_WHEN_FULL(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .input_axis_tdata(in_tdata), .input_axis_tkeep(in_tkeep),
    .input_axis_tvalid(in_tvalid), .input_axis_tready(d1_tready),
    .input_axis_tlast(in_tlast), .input_axis_tuser(in_tuser),
    .output_axis_tdata(d1_tdata), .output_axis_tkeep(d1_tkeep),
    .output_axis_tvalid(d1_tvalid), .output_axis_tready(o_tready),
    .output_axis_tlast(d1_tlast), .frame_count(d1_fc),
    .overflow(d1_ov), .bad_frame(d1_bad), .good_frame(d1_good)
  );

  always_comb begin
    m_tdata     = sel ? d1_tdata  : d0_tdata;
    m_tkeep     = sel ? d1_tkeep  : d0_tkeep;
    m_tvalid    = sel ? d1_tvalid : d0_tvalid;
    m_tlast     = sel ? d1_tlast  : d0_tlast;
    m_in_tready = sel ? d1_tready : d0_tready;
    m_fc        = sel ? d1_fc     : d0_fc;
    m_ov        = sel ? d1_ov     : d0_ov;
    m_bad       = sel ? d1_bad    : d0_bad;
    m_good      = sel ? d1_good   : d0_good;
  end

  int n_tests = 0, n_fail = 0;
  int n_out = 0, n_good = 0, n_bad = 0, n_ov = 0, max_fc = 0;
  bit d1_low = 1'b0;
  logic [9:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // random output back-pressure
  initial forever begin
    @(posedge clk); #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // monitor: handshakes complete at the next rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && o_tready) begin
        n_out++;
        if (sb.size() == 0) chk("out_extra", 32'(sb.size()), 1);
        else chk("out_beat", {m_tlast, m_tkeep, m_tdata}, sb.pop_front());
      end
      if (m_good) n_good++;
      if (m_bad)  n_bad++;
      if (m_ov)   n_ov++;
      if (int'(m_fc) > max_fc) max_fc = int'(m_fc);
      if (!d1_tready) d1_low = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0; in_tuser = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    sb.delete();
    n_out = 0; n_good = 0; n_bad = 0; n_ov = 0; max_fc = 0; d1_low = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic last, input logic user);
    bit acc = 1'b0;
    in_tdata = d; in_tlast = last; in_tuser = user; in_tvalid = 1'b1;
    for (int w = 0; w < 300 && !acc; w++) begin
      @(negedge clk); acc = m_in_tready;
      @(posedge clk); #1;
    end
    in_tvalid = 1'b0; in_tlast = 1'b0; in_tuser = 1'b0;
    chk("in_accept", 32'(acc), 1);
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic user, input bit keep);
    for (int k = 0; k < n; k++) begin
      if (keep) sb.push_back({(k == n-1), 1'b1, base + 8'(k)});
      beat(base + 8'(k), (k == n-1), user);
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || m_tvalid) && w < 2000) begin
      @(posedge clk); #1; w++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("drain_left", 32'(sb.size()), 0);
  endtask

  initial begin
    // reset state
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_tready_dwf0", 32'(d0_tready), 0);
    chk("rst_tready_dwf1", 32'(d1_tready), 1);
    chk("rst_tvalid", 32'(d0_tvalid | d1_tvalid), 0);
    chk("rst_fc", 32'(d0_fc), 0);
    rst_n = 1'b1; #1;
    chk("post_rst_tready", 32'(d0_tready), 1);
    @(posedge clk); #1;

    // 3-beat frame, latency and frame_count
    sel = 1'b0; otready_set = 1'b1; do_reset();
    send_frame(3, 8'h11, 1'b0, 1'b1);
    chk("lat_tvalid_e1", 32'(m_tvalid), 0);
    chk("lat_fc1", 32'(m_fc), 1);
    @(posedge clk); #1;
    chk("lat_tvalid_e2", 32'(m_tvalid), 1);
    chk("lat_first", 32'(m_tdata), 32'h11);
    drain();
    chk("t1_fc0", 32'(m_fc), 0);
    chk("t1_nout", 32'(n_out), 3);
    chk("t1_good", 32'(n_good), 32'(STATUS));

    // bad frame discarded, next frame passes
    do_reset();
    send_frame(2, 8'hA0, 1'b1, 1'b0);
    send_frame(1, 8'hB0, 1'b0, 1'b1);
    drain();
    chk("t2_nout", 32'(n_out), 1);
    chk("t2_bad", 32'(n_bad), 32'(STATUS));

    // drop-when-full: storage plus output register hold 5 beats, so a
    // 3-beat frame followed by a 4-beat frame cannot both fit
    sel = 1'b1; otready_set = 1'b0; do_reset();
    send_frame(3, 8'hC0, 1'b0, 1'b1);
    send_frame(4, 8'hD0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("t3_tready_low", 32'(d1_low), 0);
    chk("t3_ovf", 32'(n_ov), 32'(STATUS));
    chk("t3_fc", 32'(m_fc), 1);
    otready_set = 1'b1;
    drain();
    chk("t3_nout", 32'(n_out), 3);
    chk("t3_fc0", 32'(m_fc), 0);

    // oversize frame with back-pressure mode
    sel = 1'b0; do_reset();
    send_frame(6, 8'hE0, 1'b0, 1'b0);
    send_frame(2, 8'hF0, 1'b0, 1'b1);
    drain();
    chk("t4_nout", 32'(n_out), 2);
    chk("t4_ovf", 32'(n_ov), 32'(STATUS));

    // reset mid-frame with a stored frame pending
    otready_set = 1'b0; do_reset();
    send_frame(2, 8'h60, 1'b0, 1'b0);
    beat(8'h70, 1'b0, 1'b0);
    beat(8'h71, 1'b0, 1'b0);
    do_reset();
    chk("t5_tvalid", 32'(m_tvalid), 0);
    chk("t5_fc", 32'(m_fc), 0);
    otready_set = 1'b1;
    send_frame(1, 8'h55, 1'b0, 1'b1);
    drain();
    chk("t5_nout", 32'(n_out), 1);

    // 20 back-to-back frames, random back-pressure, pointer wrap
    do_reset(); rand_en = 1'b1;
    for (int i = 0; i < 20; i++) send_frame(3, 8'(i*3), 1'b0, 1'b1);
    drain();
    rand_en = 1'b0;
    chk("t6_nout", 32'(n_out), 60);
    chk("t6_fc_le4", 32'(max_fc <= 4), 1);
    chk("t6_fc0", 32'(m_fc), 0);
    chk("t6_good", 32'(n_good), 32'(STATUS * 20));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
